// File: rtl/scl_schmitt_debounce_ctrl.sv
// Multi-channel pad conditioner: 2-flop synchroniser, shared tick prescaler
// and per-channel debounce FSM with filtered level and rise/fall event pulses.
module scl_schmitt_debounce_ctrl #(
    parameter int   N_CH    = 4,
    parameter int   CNT_W   = 8,
    parameter int   PRESC_W = 8,
    parameter logic RST_VAL = 1'b0
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               en_i,
    input  logic [PRESC_W-1:0] presc_i,
    input  logic [CNT_W-1:0]   thresh_i,
    input  logic [N_CH-1:0]    pad_i,
    output logic [N_CH-1:0]    level_o,
    output logic [N_CH-1:0]    rise_o,
    output logic [N_CH-1:0]    fall_o,
    output logic [N_CH-1:0]    busy_o
);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_CAND   = 1'b1
    } state_e;

    logic [N_CH-1:0]    s1_q;
    logic [N_CH-1:0]    s2_q;
    logic [PRESC_W-1:0] presc_cnt_q;
    logic [PRESC_W-1:0] presc_cnt_d;
    logic               tick;

    state_e             state_q [N_CH];
    state_e             state_d [N_CH];
    logic [CNT_W-1:0]   count_q [N_CH];
    logic [CNT_W-1:0]   count_d [N_CH];
    logic [N_CH-1:0]    level_q;
    logic [N_CH-1:0]    level_d;
    logic [N_CH-1:0]    rise_q;
    logic [N_CH-1:0]    rise_d;
    logic [N_CH-1:0]    fall_q;
    logic [N_CH-1:0]    fall_d;
    logic [N_CH-1:0]    mismatch;

    assign mismatch = s2_q ^ level_q;

    // Shared prescaler: ticks when the count reaches (or passes) presc_i.
    always_comb begin
        tick        = 1'b0;
        presc_cnt_d = '0;
        if (en_i) begin
            if (presc_cnt_q >= presc_i) begin
                tick        = 1'b1;
                presc_cnt_d = '0;
            end else begin
                presc_cnt_d = presc_cnt_q + PRESC_W'(1);
            end
        end
    end

    // Per-channel debounce next-state; a tick seen in STABLE is not counted.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            count_d[i] = count_q[i];
            level_d[i] = level_q[i];
            rise_d[i]  = 1'b0;
            fall_d[i]  = 1'b0;
            unique case (state_q[i])
                ST_STABLE: begin
                    if (mismatch[i] && en_i) begin
                        state_d[i] = ST_CAND;
                        count_d[i] = '0;
                    end
                end
                ST_CAND: begin
                    if (!en_i) begin
                        state_d[i] = ST_STABLE;
                        count_d[i] = '0;
                    end else if (!mismatch[i]) begin
                        state_d[i] = ST_STABLE;
                        count_d[i] = '0;
                    end else if (tick && (count_q[i] >= thresh_i)) begin
                        state_d[i] = ST_STABLE;
                        count_d[i] = '0;
                        level_d[i] = s2_q[i];
                        rise_d[i]  = s2_q[i];
                        fall_d[i]  = ~s2_q[i];
                    end else if (tick) begin
                        if (count_q[i] != {CNT_W{1'b1}}) begin
                            count_d[i] = count_q[i] + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d[i] = ST_STABLE;
                    count_d[i] = '0;
                end
            endcase
        end
    end

    // All state registers; reset abandons any candidate without a pulse.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            s1_q        <= {N_CH{RST_VAL}};
            s2_q        <= {N_CH{RST_VAL}};
            presc_cnt_q <= '0;
            level_q     <= {N_CH{RST_VAL}};
            rise_q      <= '0;
            fall_q      <= '0;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= ST_STABLE;
                count_q[i] <= '0;
            end
        end else begin
            s1_q        <= pad_i;
            s2_q        <= s1_q;
            presc_cnt_q <= presc_cnt_d;
            level_q     <= level_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                count_q[i] <= count_d[i];
            end
        end
    end

    // Busy flag straight from the registered state.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            busy_o[i] = (state_q[i] == ST_CAND);
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: tb/tb_scl_schmitt_debounce_ctrl.sv
// Directed bench for scl_schmitt_debounce_ctrl: reset, latency, glitch
// rejection, reset mid-count, enable gating, simultaneous commits.
module tb_scl_schmitt_debounce_ctrl;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] presc;
    logic [7:0] thresh;
    logic [3:0] pad;
    logic [3:0] level;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] busy;

    int checks;
    int errors;

    scl_schmitt_debounce_ctrl #(
        .N_CH    (4),
        .CNT_W   (8),
        .PRESC_W (8),
        .RST_VAL (1'b0)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .en_i     (en),
        .presc_i  (presc),
        .thresh_i (thresh),
        .pad_i    (pad),
        .level_o  (level),
        .rise_o   (rise),
        .fall_o   (fall),
        .busy_o   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge, then settle before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int first;
        int nrise;
        int nfall;
        int both;
        int sbusy;
        int spulse;
        int slvl;
        int bad;

        checks = 0;
        errors = 0;
        rst    = 1'b1;
        en     = 1'b1;
        presc  = 8'd0;
        thresh = 8'd0;
        pad    = 4'b0000;
        repeat (3) step();
        chk("rst_level", level, 0);
        chk("rst_rise", rise, 0);
        chk("rst_fall", fall, 0);
        chk("rst_busy", busy, 0);

        // Test 1: P=0 T=0, pad[0] rises before edge 0
        rst = 1'b0;
        pad = 4'b0001;
        step();
        chk("t1_e0_busy", busy, 0);
        step();
        chk("t1_e1_busy", busy, 0);
        step();
        chk("t1_e2_busy", busy, 4'b0001);
        chk("t1_e2_level", level, 0);
        step();
        chk("t1_e3_level", level, 4'b0001);
        chk("t1_e3_rise", rise, 4'b0001);
        chk("t1_e3_busy", busy, 0);
        step();
        chk("t1_e4_rise", rise, 0);
        chk("t1_e4_level", level, 4'b0001);

        // Test 2: P=3 T=2, two-cycle glitch on pad[1]
        presc = 8'd3;
        thresh = 8'd2;
        pad = 4'b0011;
        step();
        step();
        pad = 4'b0001;
        sbusy = 0;
        spulse = 0;
        slvl = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            sbusy |= int'(busy[1]);
            spulse |= int'(rise[1] | fall[1]);
            slvl |= int'(level[1]);
        end
        chk("t2_busy_seen", sbusy, 1);
        chk("t2_no_pulse", spulse, 0);
        chk("t2_level_low", slvl, 0);

        // Test 3: pad[1] held high then released
        pad = 4'b0011;
        first = -1;
        nrise = 0;
        nfall = 0;
        both = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (level[1] && first < 0) first = k;
            nrise += int'(rise[1]);
            nfall += int'(fall[1]);
            both |= int'(|(rise & fall));
        end
        chk("t3_rise_window", int'(first >= 11 && first <= 14), 1);
        chk("t3_rise_count", nrise, 1);
        chk("t3_no_fall", nfall, 0);
        pad = 4'b0001;
        first = -1;
        nrise = 0;
        nfall = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (!level[1] && first < 0) first = k;
            nrise += int'(rise[1]);
            nfall += int'(fall[1]);
            both |= int'(|(rise & fall));
        end
        chk("t3_fall_window", int'(first >= 11 && first <= 14), 1);
        chk("t3_fall_count", nfall, 1);
        chk("t3_no_rise", nrise, 0);
        chk("t3_rise_fall_excl", both, 0);

        // Test 4: reset while channel 2 is a candidate
        pad = 4'b0101;
        repeat (4) step();
        chk("t4_busy_pre", int'(busy[2]), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t4_rst_level", level, 0);
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_rise", rise, 0);
        chk("t4_rst_fall", fall, 0);
        first = -1;
        nrise = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (level[2] && first < 0) first = k;
            nrise += int'(rise[2]);
        end
        chk("t4_requal_edge", first, 11);
        chk("t4_requal_rise", nrise, 1);
        chk("t4_level", level, 4'b0101);

        // Test 5: disabled while pad[2] toggles
        en = 1'b0;
        bad = 0;
        pad = 4'b0001;
        step();
        bad |= int'((|rise) | (|fall) | (|busy) | (level != 4'b0101));
        pad = 4'b0101;
        step();
        bad |= int'((|rise) | (|fall) | (|busy) | (level != 4'b0101));
        pad = 4'b0001;
        step();
        bad |= int'((|rise) | (|fall) | (|busy) | (level != 4'b0101));
        pad = 4'b0101;
        step();
        bad |= int'((|rise) | (|fall) | (|busy) | (level != 4'b0101));
        pad = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            step();
            bad |= int'((|rise) | (|fall) | (|busy) | (level != 4'b0101));
        end
        chk("t5_frozen", bad, 0);
        en = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            step();
            if (k == 10) chk("t5_e10_level", int'(level[2]), 1);
            if (k == 11) begin
                chk("t5_e11_level", int'(level[2]), 0);
                chk("t5_e11_fall", fall, 4'b0100);
            end
            if (k == 12) chk("t5_e12_fall", fall, 0);
        end

        // Test 6: all channels change together, then threshold raised
        presc = 8'd0;
        thresh = 8'd0;
        pad = 4'b1110;
        step();
        step();
        step();
        chk("t6_e2_busy", busy, 4'b1111);
        chk("t6_e2_level", level, 4'b0001);
        step();
        chk("t6_e3_level", level, 4'b1110);
        chk("t6_e3_rise", rise, 4'b1110);
        chk("t6_e3_fall", fall, 4'b0001);
        chk("t6_e3_busy", busy, 0);
        step();
        chk("t6_e4_pulses", int'({rise, fall}), 0);
        pad = 4'b0001;
        step();
        step();
        step();
        chk("t6b_e2_busy", busy, 4'b1111);
        thresh = 8'd5;
        for (int k = 3; k <= 9; k++) begin
            step();
            if (k == 3) chk("t6b_e3_level", level, 4'b1110);
            if (k == 7) begin
                chk("t6b_e7_level", level, 4'b1110);
                chk("t6b_e7_busy", busy, 4'b1111);
            end
            if (k == 8) begin
                chk("t6b_e8_level", level, 4'b0001);
                chk("t6b_e8_fall", fall, 4'b1110);
                chk("t6b_e8_rise", rise, 4'b0001);
            end
            if (k == 9) chk("t6b_e9_pulses", int'({rise, fall}), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
